// File: rtl/axi_lite_echo_fifo_regs_pkg.sv
// Shared constants, register-map decode and helpers for the AXI-Lite echo/FIFO register block.
package axi_echo_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int STAT_EMPTY_BIT  = 16;
  localparam int STAT_FULL_BIT   = 17;
  localparam int STAT_OVF_BIT    = 18;
  localparam int STAT_IRQ_EN_BIT = 24;

  typedef enum logic [1:0] {
    REG_ECHO,
    REG_FIFO,
    REG_STATUS,
    REG_UNMAPPED
  } region_e;

  // Smallest r with 2^r >= value; exact for the power-of-two sizes used here.
  function automatic int log2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  function automatic region_e decode_region(input int idx, input int num_regs);
    if (idx < num_regs) return REG_ECHO;
    if (idx == num_regs) return REG_FIFO;
    if (idx == num_regs + 1) return REG_STATUS;
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/axi_lite_echo_fifo_regs_if.sv
// AXI4-Lite bus bundle between the interconnect master and the echo/FIFO register slave.
interface axi_lite_echo_fifo_regs_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axi_lite_echo_fifo_regs_fifo.sv
// Synchronous FIFO backing the echo channel; the caller guarantees push/pop legality.
module echo_sync_fifo
  import axi_echo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
  localparam int PTR_W = log2(DEPTH),
  localparam int CNT_W = log2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/axi_lite_echo_fifo_regs.sv
// AXI4-Lite slave with NUM_REGS echo registers, a FIFO echo channel, a W1C status register and a level irq.
module axi_lite_echo_fifo_regs
  import axi_echo_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int NUM_REGS           = 4,
  parameter int FIFO_DEPTH         = 8,
  localparam int ADDR_LSB          = log2(C_S_AXI_DATA_WIDTH / 8),
  localparam int CNT_W             = log2(FIFO_DEPTH) + 1
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  axi_lite_echo_fifo_regs_if.slave s_axi,
  output logic [CNT_W-1:0]         fifo_level,
  output logic                     irq
);

  localparam int DW    = C_S_AXI_DATA_WIDTH;
  localparam int SW    = DW / 8;
  localparam int IDX_W = C_S_AXI_ADDR_WIDTH - ADDR_LSB;

  logic [IDX_W-1:0] wr_idx, rd_idx;
  region_e          wr_region, rd_region;
  logic             wr_fire, rd_fire;
  logic [DW-1:0]    wmask, push_data, status_word;

  logic             push, pop;
  logic [DW-1:0]    fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  logic             awready_q, awready_d;
  logic             bvalid_q, bvalid_d;
  logic [1:0]       bresp_q, bresp_d;
  logic             arready_q, arready_d;
  logic             rvalid_q, rvalid_d;
  logic [1:0]       rresp_q, rresp_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    echo_q [NUM_REGS];
  logic [DW-1:0]    echo_d [NUM_REGS];
  logic             ovf_q, ovf_d;
  logic             irq_en_q, irq_en_d;
  logic             irq_q, irq_d;
  logic             unused_bits;

  assign wr_idx    = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx    = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
  assign wr_region = decode_region(int'(wr_idx), NUM_REGS);
  assign rd_region = decode_region(int'(rd_idx), NUM_REGS);
  assign wr_fire   = awready_q && s_axi.awvalid && s_axi.wvalid;
  assign rd_fire   = arready_q && s_axi.arvalid;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < SW; b++) wmask[8*b +: 8] = {8{s_axi.wstrb[b]}};
  end

  // A pop in the same cycle frees the slot, so a push at full still succeeds.
  assign pop       = rd_fire && (rd_region == REG_FIFO) && !fifo_empty;
  assign push      = wr_fire && (wr_region == REG_FIFO) && (!fifo_full || pop);
  assign push_data = s_axi.wdata & wmask;

  echo_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                  = '0;
    status_word[CNT_W-1:0]       = fifo_count;
    status_word[STAT_EMPTY_BIT]  = fifo_empty;
    status_word[STAT_FULL_BIT]   = fifo_full;
    status_word[STAT_OVF_BIT]    = ovf_q;
    status_word[STAT_IRQ_EN_BIT] = irq_en_q;
  end

  always_comb begin
    echo_d    = echo_q;
    ovf_d     = ovf_q;
    irq_en_d  = irq_en_q;
    bresp_d   = bresp_q;
    awready_d = s_axi.awvalid && s_axi.wvalid && !bvalid_q && !awready_q;
    bvalid_d  = bvalid_q && !s_axi.bready;
    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (wr_region)
        REG_ECHO: begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) echo_d[i] = (echo_q[i] & ~wmask) | push_data;
          end
        end
        REG_FIFO: begin
          if (!push) begin
            ovf_d   = 1'b1;
            bresp_d = RESP_SLVERR;
          end
        end
        REG_STATUS: begin
          if (s_axi.wdata[STAT_OVF_BIT]) ovf_d = 1'b0;
          if (s_axi.wstrb[3]) irq_en_d = s_axi.wdata[STAT_IRQ_EN_BIT];
        end
        default: bresp_d = RESP_SLVERR;
      endcase
    end
  end

  // Read data is captured at the AR handshake, which is also when a FIFO pop happens.
  always_comb begin
    arready_d = s_axi.arvalid && !rvalid_q && !arready_q;
    rvalid_d  = rvalid_q && !s_axi.rready;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      case (rd_region)
        REG_ECHO: begin
          rresp_d = RESP_OKAY;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) rdata_d = echo_q[i];
          end
        end
        REG_FIFO: begin
          if (!fifo_empty) begin
            rdata_d = fifo_rdata;
            rresp_d = RESP_OKAY;
          end
        end
        REG_STATUS: begin
          rdata_d = status_word;
          rresp_d = RESP_OKAY;
        end
        default: ;
      endcase
    end
  end

  assign irq_d = irq_en_q && (!fifo_empty || ovf_q);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) echo_q[i] <= '0;
      ovf_q     <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      echo_q    <= echo_d;
      ovf_q     <= ovf_d;
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = awready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rresp   = rresp_q;
  assign s_axi.rdata   = rdata_q;
  assign fifo_level    = fifo_count;
  assign irq           = irq_q;

  // Protection bits and sub-word address bits carry no meaning for this slave.
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[ADDR_LSB-1:0], s_axi.araddr[ADDR_LSB-1:0]};

endmodule

// File: tb/tb_axi_lite_echo_fifo_regs.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based register model.
module tb_axi_lite_echo_fifo_regs;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int NUM_REGS = 4;
  localparam int FIFO_DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int FIFO_IDX = NUM_REGS;
  localparam int STATUS_IDX = NUM_REGS + 1;
  localparam int TIMEOUT = 20;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CNT_W-1:0] fifo_level;
  logic irq;
  int checks = 0;
  int errors = 0;

  axi_lite_echo_fifo_regs_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi_lite_echo_fifo_regs #(
    .C_S_AXI_DATA_WIDTH (DW),
    .C_S_AXI_ADDR_WIDTH (AW),
    .NUM_REGS           (NUM_REGS),
    .FIFO_DEPTH         (FIFO_DEPTH)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (bus.slave),
    .fifo_level    (fifo_level),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  logic [31:0] m_echo [NUM_REGS];
  logic [31:0] m_fifo [$];
  bit          m_ovf;
  bit          m_irq_en;

  function automatic void model_reset();
    foreach (m_echo[i]) m_echo[i] = '0;
    m_fifo.delete();
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
  endfunction

  function automatic logic [31:0] strobe_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [1:0] model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = strobe_mask(s);
    if (idx < NUM_REGS) begin
      m_echo[idx] = (m_echo[idx] & ~m) | (d & m);
      return OKAY;
    end
    if (idx == FIFO_IDX) begin
      if (m_fifo.size() >= FIFO_DEPTH) begin
        m_ovf = 1'b1;
        return SLVERR;
      end
      m_fifo.push_back(d & m);
      return OKAY;
    end
    if (idx == STATUS_IDX) begin
      if (d[18]) m_ovf = 1'b0;
      if (s[3]) m_irq_en = d[24];
      return OKAY;
    end
    return SLVERR;
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[CNT_W-1:0] = CNT_W'(m_fifo.size());
    s[16] = (m_fifo.size() == 0);
    s[17] = (m_fifo.size() == FIFO_DEPTH);
    s[18] = m_ovf;
    s[24] = m_irq_en;
    return s;
  endfunction

  function automatic void model_read(input int idx, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = SLVERR;
    if (idx < NUM_REGS) begin
      d = m_echo[idx];
      r = OKAY;
    end else if (idx == FIFO_IDX) begin
      if (m_fifo.size() != 0) begin
        d = m_fifo.pop_front();
        r = OKAY;
      end
    end else if (idx == STATUS_IDX) begin
      d = model_status();
      r = OKAY;
    end
  endfunction

  function automatic logic model_irq();
    return m_irq_en && ((m_fifo.size() != 0) || m_ovf);
  endfunction

  task automatic axi_write(input int idx, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.awaddr = AW'(idx * 4);
    bus.wdata = data;
    bus.wstrb = strb;
    bus.awvalid = 1'b1;
    bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    n = 0;
    while (bus.awready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= TIMEOUT || bus.wready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL aw_w_handshake idx=%0d waited=%0d wready=%b, required awready=wready=1", idx, n, bus.wready);
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
    checks++;
    if (bus.bvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bvalid_latency idx=%0d got %b, required 1", idx, bus.bvalid);
    end
    resp = bus.bresp;
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input int idx, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    bus.araddr = AW'(idx * 4);
    bus.arvalid = 1'b1;
    bus.rready = 1'b0;
    n = 0;
    while (bus.arready !== 1'b1 && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= TIMEOUT) begin
      errors++;
      $display("[TB] FAIL ar_handshake idx=%0d waited=%0d, required arready=1", idx, n);
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rvalid_latency idx=%0d got %b, required 1", idx, bus.rvalid);
    end
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d, ed;
    logic [1:0] r, er;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp,
         bus.rdata, irq, fifo_level} !== 46'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h, required 0",
               {bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, bus.bresp, bus.rresp,
                bus.rdata, irq, fifo_level});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_read(STATUS_IDX, d, r);
    model_read(STATUS_IDX, ed, er);
    checks++;
    if (d !== ed || r !== er) begin
      errors++;
      $display("[TB] FAIL reset_status got %h/%b, required %h/%b", d, r, ed, er);
    end
  endtask

  task automatic test_echo_regs();
    logic [31:0] vals [4] = '{32'h0101FFFF, 32'habcd0001, 32'hdead0011, 32'hbeef0011};
    logic [31:0] d;
    logic [1:0] r;
    for (int i = 0; i < 4; i++) begin
      axi_write(i, vals[i], 4'hF, r);
      void'(model_write(i, vals[i], 4'hF));
      checks++;
      if (r !== OKAY) begin
        errors++;
        $display("[TB] FAIL echo_bresp idx=%0d got %b, required %b", i, r, OKAY);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(i, d, r);
      checks++;
      if (d !== vals[i] || r !== OKAY) begin
        errors++;
        $display("[TB] FAIL echo_readback idx=%0d got %h/%b, required %h/%b", i, d, r, vals[i], OKAY);
      end
    end
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    logic [1:0] r;
    axi_write(1, 32'hFFFFFFFF, 4'hF, r);
    void'(model_write(1, 32'hFFFFFFFF, 4'hF));
    axi_write(1, 32'h12345678, 4'b0101, r);
    void'(model_write(1, 32'h12345678, 4'b0101));
    axi_read(1, d, r);
    checks++;
    if (d !== 32'hFF34FF78 || r !== OKAY) begin
      errors++;
      $display("[TB] FAIL strobe_merge got %h/%b, required %h/%b", d, r, 32'hFF34FF78, OKAY);
    end
  endtask

  task automatic test_fifo_fill_drain();
    logic [31:0] d, ed;
    logic [1:0] r, er;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      axi_write(FIFO_IDX, 32'hA0 + k, 4'hF, r);
      er = model_write(FIFO_IDX, 32'hA0 + k, 4'hF);
      checks++;
      if (r !== er) begin
        errors++;
        $display("[TB] FAIL fifo_push_resp k=%0d got %b, required %b", k, r, er);
      end
    end
    axi_read(STATUS_IDX, d, r);
    checks++;
    if (d !== 32'h00020008 || r !== OKAY) begin
      errors++;
      $display("[TB] FAIL status_full got %h/%b, required %h/%b", d, r, 32'h00020008, OKAY);
    end
    axi_write(FIFO_IDX, 32'hA8, 4'hF, r);
    er = model_write(FIFO_IDX, 32'hA8, 4'hF);
    checks++;
    if (r !== er) begin
      errors++;
      $display("[TB] FAIL fifo_overflow_resp got %b, required %b", r, er);
    end
    axi_read(STATUS_IDX, d, r);
    model_read(STATUS_IDX, ed, er);
    checks++;
    if (d !== ed || r !== er) begin
      errors++;
      $display("[TB] FAIL status_ovf got %h/%b, required %h/%b", d, r, ed, er);
    end
    for (int k = 0; k <= FIFO_DEPTH; k++) begin
      axi_read(FIFO_IDX, d, r);
      model_read(FIFO_IDX, ed, er);
      checks++;
      if (d !== ed || r !== er) begin
        errors++;
        $display("[TB] FAIL fifo_pop k=%0d got %h/%b, required %h/%b", k, d, r, ed, er);
      end
    end
    axi_write(STATUS_IDX, 32'h00040000, 4'hF, r);
    void'(model_write(STATUS_IDX, 32'h00040000, 4'hF));
  endtask

  task automatic test_irq();
    logic [31:0] d, ed;
    logic [1:0] r, er;
    axi_write(STATUS_IDX, 32'h01000000, 4'hF, r);
    void'(model_write(STATUS_IDX, 32'h01000000, 4'hF));
    checks++;
    if (irq !== model_irq()) begin
      errors++;
      $display("[TB] FAIL irq_enable_only got %b, required %b", irq, model_irq());
    end
    axi_write(FIFO_IDX, 32'h55, 4'hF, r);
    void'(model_write(FIFO_IDX, 32'h55, 4'hF));
    checks++;
    if (irq !== model_irq()) begin
      errors++;
      $display("[TB] FAIL irq_after_push got %b, required %b", irq, model_irq());
    end
    axi_read(FIFO_IDX, d, r);
    model_read(FIFO_IDX, ed, er);
    checks++;
    if (irq !== model_irq() || d !== ed) begin
      errors++;
      $display("[TB] FAIL irq_after_pop got %b/%h, required %b/%h", irq, d, model_irq(), ed);
    end
    for (int k = 0; k <= FIFO_DEPTH; k++) begin
      axi_write(FIFO_IDX, $urandom, 4'hF, r);
      void'(model_write(FIFO_IDX, 32'h0, 4'hF));
    end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      axi_read(FIFO_IDX, d, r);
      model_read(FIFO_IDX, ed, er);
    end
    checks++;
    if (irq !== model_irq() || fifo_level !== CNT_W'(m_fifo.size())) begin
      errors++;
      $display("[TB] FAIL irq_ovf_sticky got irq=%b level=%0d, required irq=%b level=%0d",
               irq, fifo_level, model_irq(), m_fifo.size());
    end
    axi_write(STATUS_IDX, 32'h01040000, 4'hF, r);
    void'(model_write(STATUS_IDX, 32'h01040000, 4'hF));
    @(negedge clk);
    checks++;
    if (irq !== model_irq()) begin
      errors++;
      $display("[TB] FAIL irq_w1c got %b, required %b", irq, model_irq());
    end
    axi_write(STATUS_IDX, 32'h0, 4'hF, r);
    void'(model_write(STATUS_IDX, 32'h0, 4'hF));
  endtask

  task automatic test_unmapped();
    logic [31:0] d, ed;
    logic [1:0] r, er;
    int idxs [2] = '{NUM_REGS + 2, 15};
    foreach (idxs[j]) begin
      axi_write(idxs[j], $urandom, 4'hF, r);
      er = model_write(idxs[j], 32'h0, 4'hF);
      checks++;
      if (r !== er) begin
        errors++;
        $display("[TB] FAIL unmapped_bresp idx=%0d got %b, required %b", idxs[j], r, er);
      end
      axi_read(idxs[j], d, r);
      model_read(idxs[j], ed, er);
      checks++;
      if (d !== ed || r !== er) begin
        errors++;
        $display("[TB] FAIL unmapped_read idx=%0d got %h/%b, required %h/%b", idxs[j], d, r, ed, er);
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      axi_read(i, d, r);
      model_read(i, ed, er);
      checks++;
      if (d !== ed) begin
        errors++;
        $display("[TB] FAIL unmapped_side_effect idx=%0d got %h, required %h", i, d, ed);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] d, ed, wd;
    logic [1:0] rr, er, rb, eb;
    while (m_fifo.size() < FIFO_DEPTH) begin
      wd = $urandom;
      axi_write(FIFO_IDX, wd, 4'hF, rb);
      void'(model_write(FIFO_IDX, wd, 4'hF));
    end
    for (int pass = 0; pass < 2; pass++) begin
      wd = $urandom;
      fork
        axi_write(FIFO_IDX, wd, 4'hF, rb);
        axi_read(FIFO_IDX, d, rr);
      join
      model_read(FIFO_IDX, ed, er);
      eb = model_write(FIFO_IDX, wd, 4'hF);
      checks++;
      if (d !== ed || rr !== er || rb !== eb || fifo_level !== CNT_W'(m_fifo.size())) begin
        errors++;
        $display("[TB] FAIL push_pop_same_cycle pass=%0d got %h/%b/%b lvl=%0d, required %h/%b/%b lvl=%0d",
                 pass, d, rr, rb, fifo_level, ed, er, eb, m_fifo.size());
      end
      if (pass == 0) begin
        while (m_fifo.size() != 0) begin
          axi_read(FIFO_IDX, d, rr);
          model_read(FIFO_IDX, ed, er);
          checks++;
          if (d !== ed || rr !== er) begin
            errors++;
            $display("[TB] FAIL drain_after_simul got %h/%b, required %h/%b", d, rr, ed, er);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] d, ed, wd;
    logic [1:0] r, er;
    logic [3:0] strb;
    int op, idx;
    bit is_read;
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 7);
      wd = $urandom;
      strb = 4'($urandom_range(0, 15));
      is_read = 1'b0;
      case (op)
        0: idx = $urandom_range(0, NUM_REGS - 1);
        1: begin idx = $urandom_range(0, NUM_REGS - 1); is_read = 1'b1; end
        2, 7: idx = FIFO_IDX;
        3: begin idx = FIFO_IDX; is_read = 1'b1; end
        4: begin idx = STATUS_IDX; is_read = 1'b1; end
        5: begin idx = STATUS_IDX; wd = wd & 32'h010400FF; end
        default: begin idx = $urandom_range(NUM_REGS + 2, 15); is_read = ($urandom_range(0, 1) == 1); end
      endcase
      if (is_read) begin
        axi_read(idx, d, r);
        model_read(idx, ed, er);
        checks++;
        if (d !== ed || r !== er) begin
          errors++;
          $display("[TB] FAIL rnd_read k=%0d idx=%0d got %h/%b, required %h/%b", k, idx, d, r, ed, er);
        end
      end else begin
        axi_write(idx, wd, strb, r);
        er = model_write(idx, wd, strb);
        checks++;
        if (r !== er) begin
          errors++;
          $display("[TB] FAIL rnd_write k=%0d idx=%0d got %b, required %b", k, idx, r, er);
        end
      end
      checks++;
      if (fifo_level !== CNT_W'(m_fifo.size()) || irq !== model_irq()) begin
        errors++;
        $display("[TB] FAIL rnd_level_irq k=%0d got %0d/%b, required %0d/%b",
                 k, fifo_level, irq, m_fifo.size(), model_irq());
      end
    end
  endtask

  task automatic test_backpressure_reset();
    logic [31:0] d0, d, ed, exp_rd;
    logic [1:0] r, er, exp_b, exp_r;
    int n;
    d0 = $urandom;
    exp_b = model_write(0, d0, 4'hF);
    model_read(1, exp_rd, exp_r);
    @(negedge clk);
    bus.awaddr = AW'(0); bus.wdata = d0; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b0;
    bus.araddr = AW'(4); bus.arvalid = 1'b1; bus.rready = 1'b0;
    n = 0;
    while (!(bus.bvalid === 1'b1 && bus.rvalid === 1'b1) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= TIMEOUT) begin
      errors++;
      $display("[TB] FAIL bp_first_accept waited=%0d, required bvalid=rvalid=1", n);
    end
    bus.awaddr = AW'(8);
    bus.wdata = ~d0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.bvalid !== 1'b1 || bus.bresp !== exp_b) begin
        errors++;
        $display("[TB] FAIL bp_b_hold c=%0d got %b/%b, required 1/%b", c, bus.bvalid, bus.bresp, exp_b);
      end
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== exp_rd || bus.rresp !== exp_r) begin
        errors++;
        $display("[TB] FAIL bp_r_hold c=%0d got %b/%h/%b, required 1/%h/%b",
                 c, bus.rvalid, bus.rdata, bus.rresp, exp_rd, exp_r);
      end
      checks++;
      if (bus.awready !== 1'b0 || bus.arready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_no_accept c=%0d got aw=%b ar=%b, required 0/0", c, bus.awready, bus.arready);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready, irq} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL async_reset_drop got %b, required 000000",
               {bus.bvalid, bus.rvalid, bus.awready, bus.wready, bus.arready, irq});
    end
    model_reset();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i <= 2; i++) begin
      axi_read(i, d, r);
      model_read(i, ed, er);
      checks++;
      if (d !== ed || r !== er) begin
        errors++;
        $display("[TB] FAIL post_reset_echo idx=%0d got %h/%b, required %h/%b", i, d, r, ed, er);
      end
    end
  endtask

  initial begin
    test_reset();
    test_echo_regs();
    test_strobes();
    test_fifo_fill_drain();
    test_irq();
    test_unmapped();
    test_simultaneous();
    test_random();
    test_backpressure_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
